// File: rtl/ddr_burst_scheduler_if.sv
// ddr_burst_scheduler_if
// Groups the requester handshake and AXI command bus of the DDR burst
// scheduler.
//   req_valid/req_ready : per-channel line-burst request and accept pulse
//   frame_start         : per-channel line counter clear
//   cmd_*               : command to the shared AXI full-burst master
//   cmd_done            : burst completion pulse from the master
//   busy                : scheduler owns the master (CMD or WAIT)
// Modport master is the scheduler side; modport slave is the
// requester/AXI-master side.
interface ddr_burst_scheduler_if #(
  parameter int ADDR_W = 32
);
  logic [3:0]        req_valid;
  logic [3:0]        req_ready;
  logic [3:0]        frame_start;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [15:0]       cmd_len;
  logic              cmd_wr;
  logic [1:0]        cmd_id;
  logic              cmd_done;
  logic              busy;

  modport master (
    input  req_valid, frame_start, cmd_ready, cmd_done,
    output req_ready, cmd_valid, cmd_addr, cmd_len, cmd_wr, cmd_id, busy
  );

  modport slave (
    output req_valid, frame_start, cmd_ready, cmd_done,
    input  req_ready, cmd_valid, cmd_addr, cmd_len, cmd_wr, cmd_id, busy
  );
endinterface

// File: rtl/ddr_burst_scheduler.sv
// ddr_burst_scheduler
// Shares one AXI full-burst master between four line-burst requesters:
// ch0/ch1 are camera writers, ch2/ch3 are video readers. Requests are
// arbitrated round-robin in IDLE, one line command is issued at a time and
// the master is held until cmd_done. Each channel's DDR line address comes
// from its own line counter, which wraps at V_LINES and is cleared by
// frame_start.
// Ports:
//   video_clk : clock for all logic
//   video_rst : asynchronous active-high reset
//   bus       : ddr_burst_scheduler_if.master (request handshake, command
//               bus, cmd_done, busy)
module ddr_burst_scheduler #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 'h0000_0000,
  parameter logic [ADDR_W-1:0] CH_STRIDE  = 'h0080_0000,
  parameter int                LINE_BYTES = 7680,
  parameter int                LINE_BEATS = 480,
  parameter int                V_LINES    = 1080
) (
  input logic                   video_clk,
  input logic                   video_rst,
  ddr_burst_scheduler_if.master bus
);

  localparam int LC_W = (V_LINES > 1) ? $clog2(V_LINES) : 1;

  typedef enum logic [1:0] {IDLE, CMD, WAIT} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              cmd_valid_r;
  logic [ADDR_W-1:0] cmd_addr_r;
  logic              cmd_wr_r;
  logic [1:0]        cmd_id_r;
  logic [1:0]        last_grant;
  logic [LC_W-1:0]   line_cnt [4];

  logic              grant_hit;
  logic [1:0]        grant_id;
  logic              accept;
  logic [ADDR_W-1:0] grant_addr;

  // Round-robin pick: first set request after 'last', wrapping mod 4.
  // The loop runs backwards so the nearest candidate is assigned last.
  function automatic logic [2:0] rr_pick(input logic [1:0] last,
                                         input logic [3:0] req);
    logic [1:0] idx;
    logic [2:0] res;
    res = {1'b0, last};
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    state_nxt             = state;
    accept                = 1'b0;
    {grant_hit, grant_id} = rr_pick(last_grant, bus.req_valid);
    case (state)
      IDLE: if (grant_hit) state_nxt = CMD;
      CMD: begin
        if (bus.cmd_ready) begin
          accept    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: if (bus.cmd_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Unsigned address arithmetic, truncated to ADDR_W.
  assign grant_addr = BASE_ADDR
                    + ADDR_W'(grant_id) * CH_STRIDE
                    + ADDR_W'(line_cnt[grant_id]) * ADDR_W'(LINE_BYTES);

  always_ff @(posedge video_clk or posedge video_rst) begin
    if (video_rst) begin
      state       <= IDLE;
      cmd_valid_r <= 1'b0;
      cmd_addr_r  <= '0;
      cmd_wr_r    <= 1'b0;
      cmd_id_r    <= 2'd0;
      last_grant  <= 2'd3;
    end else begin
      state <= state_nxt;
      if (state == IDLE && grant_hit) begin
        cmd_valid_r <= 1'b1;
        cmd_id_r    <= grant_id;
        cmd_wr_r    <= ~grant_id[1];
        cmd_addr_r  <= grant_addr;
      end
      if (accept) begin
        cmd_valid_r <= 1'b0;
        last_grant  <= cmd_id_r;
      end
    end
  end

  // frame_start has priority over the accept increment of the same channel.
  always_ff @(posedge video_clk or posedge video_rst) begin
    if (video_rst) begin
      for (int n = 0; n < 4; n++) line_cnt[n] <= '0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (bus.frame_start[n]) begin
          line_cnt[n] <= '0;
        end else if (accept && cmd_id_r == 2'(n)) begin
          line_cnt[n] <= (line_cnt[n] == LC_W'(V_LINES - 1)) ? '0
                                                             : line_cnt[n] + 1'b1;
        end
      end
    end
  end

  // req_ready is decoded from the accept handshake so it pulses in the very
  // cycle the master takes the command.
  assign bus.req_ready = accept ? (4'b0001 << cmd_id_r) : 4'b0000;
  assign bus.cmd_valid = cmd_valid_r;
  assign bus.cmd_addr  = cmd_addr_r;
  assign bus.cmd_len   = 16'(LINE_BEATS);
  assign bus.cmd_wr    = cmd_wr_r;
  assign bus.cmd_id    = cmd_id_r;
  assign bus.busy      = (state != IDLE);

endmodule
